// File: rtl/pipe_share_sched_pkg.sv
// Shared types and helpers for the pipeline-sharing round-robin scheduler.
package pipe_share_sched_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StHalt  = 2'd2
    } state_e;

    // Ceiling log2, never below 1 so the result can size a vector directly.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pipe_share_sched_tag_fifo.sv
// Tag FIFO: remembers which requester issued each item currently in the pipeline.
module pipe_share_sched_tag_fifo
    import pipe_share_sched_pkg::*;
#(
    parameter int unsigned P_DEPTH = 6,
    parameter int unsigned P_TAGW  = 2,
    localparam int unsigned CntW   = clog2(P_DEPTH + 1),
    localparam int unsigned PtrW   = clog2(P_DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              push_i,
    input  logic [P_TAGW-1:0] tag_i,
    input  logic              pop_i,
    output logic [P_TAGW-1:0] tag_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [CntW-1:0]   count_o
);

    logic [P_TAGW-1:0] mem_q [P_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CntW'(P_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign tag_o   = mem_q[rd_ptr_q];

    // A pop of an empty FIFO is dropped; a full FIFO takes a push only alongside a pop.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Next-state for pointers and occupancy count.
    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; contents are meaningless while empty so no reset is needed.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/pipe_share_sched.sv
// Round-robin scheduler sharing one stall-compacting pipeline among several requesters.
module pipe_share_sched
    import pipe_share_sched_pkg::*;
#(
    parameter int unsigned P_REQ    = 4,
    parameter int unsigned P_STAGES = 6,
    parameter int unsigned P_WIDTH  = 32,
    parameter int unsigned P_TAGW   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [P_REQ-1:0]           i_req_valid,
    input  logic [P_REQ*P_WIDTH-1:0]   i_req_data,
    output logic [P_REQ-1:0]           o_req_ready,
    output logic [P_WIDTH-1:0]         o_pipe_in,
    output logic                       o_pipe_in_valid,
    output logic                       o_pipe_stall,
    input  logic [P_WIDTH-1:0]         i_pipe_out,
    input  logic                       i_pipe_out_valid,
    output logic [P_WIDTH-1:0]         o_out_data,
    output logic [P_TAGW-1:0]          o_out_tag,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    input  logic                       i_halt_req,
    output logic                       o_halted,
    output logic                       o_err
);

    localparam int unsigned OccW = clog2(P_STAGES + 1);
    localparam int unsigned CntW = clog2(P_STAGES + 1);

    state_e            state_q;
    logic              halted_q;
    logic [OccW-1:0]   occ_q, occ_d;
    logic [P_TAGW-1:0] last_q, last_d;
    logic              err_q, err_d;

    logic              xfer_out;
    logic              can_push;
    logic              push;
    logic              win_found;
    logic [P_TAGW-1:0] win_idx;
    int unsigned       cand;
    logic [P_TAGW-1:0] cand_idx;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CntW-1:0]   fifo_count;
    logic              unused_fifo;

    assign unused_fifo = ^{fifo_full, fifo_count};

    assign o_pipe_stall = i_pipe_out_valid & ~i_out_ready;
    assign xfer_out     = i_pipe_out_valid & i_out_ready;

    // A stalled pipeline still absorbs input while it has a bubble to compact.
    assign can_push = (state_q == StRun) & (~o_pipe_stall | (occ_q < OccW'(P_STAGES)));
    assign push     = can_push & win_found;

    assign o_pipe_in_valid = push;
    assign o_out_data      = i_pipe_out;
    assign o_out_valid     = i_pipe_out_valid;
    assign o_halted        = halted_q;
    assign o_err           = err_q;

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned i = 1; i <= P_REQ; i++) begin
            cand     = (32'(last_q) + i) % P_REQ;
            cand_idx = P_TAGW'(cand);
            if (!win_found && i_req_valid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // One-hot grant and data mux toward the pipeline input.
    always_comb begin
        o_req_ready = '0;
        o_pipe_in   = '0;
        for (int unsigned k = 0; k < P_REQ; k++) begin
            if (push && (win_idx == P_TAGW'(k))) begin
                o_req_ready[k] = 1'b1;
                o_pipe_in      = i_req_data[k*P_WIDTH +: P_WIDTH];
            end
        end
    end

    // Occupancy, round-robin pointer and sticky error next-state.
    always_comb begin
        occ_d  = occ_q;
        err_d  = err_q;
        last_d = push ? win_idx : last_q;
        if (i_pipe_out_valid && fifo_empty) begin
            err_d = 1'b1;
        end
        if (push && !xfer_out) begin
            if (occ_q == OccW'(P_STAGES)) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q + 1'b1;
            end
        end else if (xfer_out && !push) begin
            if (occ_q == '0) begin
                err_d = 1'b1;
            end else begin
                occ_d = occ_q - 1'b1;
            end
        end
    end

    // Occupancy, pointer and error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q  <= '0;
            last_q <= P_TAGW'(P_REQ - 1);
            err_q  <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            last_q <= last_d;
            err_q  <= err_d;
        end
    end

    // Drain/halt FSM; the drain completes on the cycle its last item leaves.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (i_halt_req) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!i_halt_req) begin
                        state_q <= StRun;
                    end else if (occ_d == '0) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end
                end
                StHalt: begin
                    if (!i_halt_req) begin
                        state_q  <= StRun;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= StRun;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    pipe_share_sched_tag_fifo #(
        .P_DEPTH (P_STAGES),
        .P_TAGW  (P_TAGW)
    ) u_tag_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .push_i  (push),
        .tag_i   (win_idx),
        .pop_i   (xfer_out),
        .tag_o   (o_out_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule

// File: tb/tb_pipe_share_sched.sv
// Randomized scoreboard bench for pipe_share_sched with a behavioural pipeline model.
module tb_pipe_share_sched;

    localparam int unsigned P_REQ    = 4;
    localparam int unsigned P_STAGES = 6;
    localparam int unsigned P_WIDTH  = 32;
    localparam int unsigned P_TAGW   = 2;

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_HALT  = 2;

    logic                     i_clk = 1'b0;
    logic                     i_rst;
    logic [P_REQ-1:0]         i_req_valid;
    logic [P_REQ*P_WIDTH-1:0] i_req_data;
    logic [P_REQ-1:0]         o_req_ready;
    logic [P_WIDTH-1:0]       o_pipe_in;
    logic                     o_pipe_in_valid;
    logic                     o_pipe_stall;
    logic [P_WIDTH-1:0]       i_pipe_out;
    logic                     i_pipe_out_valid;
    logic [P_WIDTH-1:0]       o_out_data;
    logic [P_TAGW-1:0]        o_out_tag;
    logic                     o_out_valid;
    logic                     i_out_ready;
    logic                     i_halt_req;
    logic                     o_halted;
    logic                     o_err;
    logic                     inject;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    pipe_share_sched #(
        .P_REQ    (P_REQ),
        .P_STAGES (P_STAGES),
        .P_WIDTH  (P_WIDTH),
        .P_TAGW   (P_TAGW)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_req_valid      (i_req_valid),
        .i_req_data       (i_req_data),
        .o_req_ready      (o_req_ready),
        .o_pipe_in        (o_pipe_in),
        .o_pipe_in_valid  (o_pipe_in_valid),
        .o_pipe_stall     (o_pipe_stall),
        .i_pipe_out       (i_pipe_out),
        .i_pipe_out_valid (i_pipe_out_valid),
        .o_out_data       (o_out_data),
        .o_out_tag        (o_out_tag),
        .o_out_valid      (o_out_valid),
        .i_out_ready      (i_out_ready),
        .i_halt_req       (i_halt_req),
        .o_halted         (o_halted),
        .o_err            (o_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- shared pipeline: stall-compacting shift register ----------------
    logic [P_STAGES-1:0] pm_v;
    logic [P_WIDTH-1:0]  pm_d [P_STAGES];
    logic                pm_lost;

    assign i_pipe_out_valid = pm_v[P_STAGES-1] | inject;
    assign i_pipe_out       = pm_d[P_STAGES-1];

    always @(posedge i_clk) begin
        logic [P_STAGES-1:0] nv;
        logic [P_WIDTH-1:0]  nd [P_STAGES];
        logic                moves;
        if (i_rst) begin
            pm_v <= '0;
        end else begin
            nv    = pm_v;
            nd    = pm_d;
            moves = !o_pipe_stall;
            for (int i = P_STAGES - 1; i >= 1; i--) begin
                if (!pm_v[i] || moves) begin
                    nv[i] = pm_v[i-1];
                    nd[i] = pm_d[i-1];
                    moves = 1'b1;
                end else begin
                    moves = 1'b0;
                end
            end
            if (!pm_v[0] || moves) begin
                nv[0] = o_pipe_in_valid;
                nd[0] = o_pipe_in;
            end else if (o_pipe_in_valid) begin
                pm_lost <= 1'b1;
            end
            pm_v <= nv;
            pm_d <= nd;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct packed {
        logic [P_WIDTH-1:0] data;
        logic [P_TAGW-1:0]  tag;
    } item_t;

    item_t       exp_q [$];
    int unsigned m_last;
    int unsigned m_infl;
    int          m_state;
    logic        m_halted;
    logic        m_err;

    // Per-cycle expectations from the scheduling rules; issued items enter the scoreboard.
    always @(negedge i_clk) begin
        logic               stall;
        logic               xfer;
        logic               can;
        logic               found;
        logic               push;
        int unsigned        win;
        int unsigned        c;
        logic [P_REQ-1:0]   exp_rdy;
        logic [P_WIDTH-1:0] exp_in;
        if (i_rst) begin
            m_last   = P_REQ - 1;
            m_infl   = 0;
            m_state  = M_RUN;
            m_halted = 1'b0;
            m_err    = 1'b0;
            exp_q.delete();
        end else begin
            stall = i_pipe_out_valid && !i_out_ready;
            xfer  = i_pipe_out_valid && i_out_ready;
            can   = (m_state == M_RUN) && (!stall || m_infl < P_STAGES);
            found = 1'b0;
            win   = 0;
            for (int o = 1; o <= int'(P_REQ); o++) begin
                c = (m_last + o) % P_REQ;
                if (!found && ((i_req_valid >> c) & 1) != 0) begin
                    found = 1'b1;
                    win   = c;
                end
            end
            push    = can && found;
            exp_rdy = push ? (P_REQ'(1) << win) : '0;
            exp_in  = push ? P_WIDTH'(i_req_data >> (win * P_WIDTH)) : '0;

            check("req_ready", o_req_ready, exp_rdy);
            check("pipe_in_valid", o_pipe_in_valid, push);
            check("pipe_in", o_pipe_in, exp_in);
            check("pipe_stall", o_pipe_stall, stall);
            check("out_valid", o_out_valid, i_pipe_out_valid);
            check("halted", o_halted, m_halted);
            check("err", o_err, m_err);

            if (push) begin
                exp_q.push_back('{data: exp_in, tag: P_TAGW'(win)});
                m_last = win;
            end
            if (i_pipe_out_valid && m_infl == 0) m_err = 1'b1;
            if (push && !xfer) begin
                if (m_infl == P_STAGES) m_err = 1'b1;
                else m_infl++;
            end else if (xfer && !push) begin
                if (m_infl == 0) m_err = 1'b1;
                else m_infl--;
            end
            case (m_state)
                M_RUN: if (i_halt_req) m_state = M_DRAIN;
                M_DRAIN: begin
                    if (!i_halt_req) begin
                        m_state = M_RUN;
                    end else if (m_infl == 0) begin
                        m_state  = M_HALT;
                        m_halted = 1'b1;
                    end
                end
                default: begin
                    if (!i_halt_req) begin
                        m_state  = M_RUN;
                        m_halted = 1'b0;
                    end
                end
            endcase
        end
    end

    // Monitor: every accepted result must match the oldest issued item.
    always @(negedge i_clk) begin
        item_t it;
        if (!i_rst && o_out_valid && i_out_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL out_unexpected: got data 0x%0h tag %0d, expected no result (t=%0t)",
                         o_out_data, o_out_tag, $time);
            end else begin
                it = exp_q.pop_front();
                check("out_data", o_out_data, it.data);
                check("out_tag", o_out_tag, it.tag);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [P_REQ-1:0] s_ready;
    logic             s_halted;
    logic             s_err;

    task automatic next();
        @(negedge i_clk);
        s_ready  = o_req_ready;
        s_halted = o_halted;
        s_err    = o_err;
        @(posedge i_clk);
        #1;
    endtask

    task automatic rand_data();
        for (int k = 0; k < int'(P_REQ); k++) i_req_data[k*P_WIDTH +: P_WIDTH] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    initial begin
        int unsigned seq;
        logic        reached;
        i_rst       = 1'b1;
        i_req_valid = '0;
        i_req_data  = '0;
        i_out_ready = 1'b1;
        i_halt_req  = 1'b0;
        inject      = 1'b0;
        pm_lost     = 1'b0;
        repeat (3) next();
        i_rst = 1'b0;

        // Reset state with no requests.
        next();
        check("reset_ready", s_ready, '0);
        check("reset_halted", s_halted, 1'b0);
        check("reset_err", s_err, 1'b0);

        // Fairness: everyone valid, no stall.
        i_req_valid = '1;
        rand_data();
        next();
        check("first_grant", s_ready, 4'b0001);
        for (int n = 0; n < 30; n++) begin
            rand_data();
            next();
        end
        i_req_valid = '0;
        repeat (10) next();

        // Stall compaction with a single requester feeding a counting sequence.
        seq         = 1;
        i_req_valid = 4'b0100;
        i_req_data[2*P_WIDTH +: P_WIDTH] = seq;
        for (int n = 0; n < 24; n++) begin
            if (n == 8) i_out_ready = 1'b0;
            next();
            if (s_ready[2]) seq++;
            i_req_data[2*P_WIDTH +: P_WIDTH] = seq;
        end
        check("stall_held", $countones(pm_v), P_STAGES);
        check("stall_ready_zero", s_ready, '0);
        i_req_valid = '0;
        i_out_ready = 1'b1;
        repeat (12) next();

        // Drain/halt with three items in flight.
        i_req_valid = 4'b0010;
        rand_data();
        repeat (3) next();
        i_req_valid = '0;
        i_halt_req  = 1'b1;
        next();
        i_req_valid = '1;
        reached     = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            next();
            reached = s_halted;
        end
        check("halt_reached", reached, 1'b1);
        i_halt_req = 1'b0;
        next();
        next();
        check("resume_grant", s_ready, 4'b0100);

        // Randomized traffic with random back-pressure and halt requests.
        for (int n = 0; n < 400; n++) begin
            i_req_valid = P_REQ'($urandom);
            rand_data();
            i_out_ready = ($urandom_range(3) != 0);
            if ($urandom_range(19) == 0) i_halt_req = ~i_halt_req;
            next();
        end
        i_req_valid = '0;
        i_halt_req  = 1'b0;
        i_out_ready = 1'b1;
        repeat (15) next();

        // Reset while the pipeline is stalled and full.
        i_req_valid = '1;
        i_out_ready = 1'b0;
        repeat (15) next();
        check("prereset_held", $countones(pm_v), P_STAGES);
        i_rst = 1'b1;
        next();
        i_rst       = 1'b0;
        i_out_ready = 1'b1;
        next();
        check("post_reset_grant", s_ready, 4'b0001);
        check("post_reset_err", s_err, 1'b0);
        i_req_valid = '0;
        repeat (12) next();

        // Error injection: output valid with nothing in flight.
        i_out_ready = 1'b0;
        inject      = 1'b1;
        next();
        inject = 1'b0;
        next();
        check("err_set", s_err, 1'b1);
        repeat (3) next();
        check("err_hold", s_err, 1'b1);
        i_rst = 1'b1;
        next();
        i_rst       = 1'b0;
        i_out_ready = 1'b1;
        next();
        check("err_cleared", s_err, 1'b0);

        check("pipe_no_overwrite", pm_lost, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
